slot_alloc: RTL and testbench

//  Tracks a pool of DEPTH slots (buffer entries, tags, ROB IDs) as a busy bitmap.

---
 rtl/slot_alloc.sv | 124 ++++++++++++
 tb/tb_slot_alloc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/slot_alloc.sv
// slot_alloc: busy-bitmap slot pool granting the lowest free index each cycle,
// accepting multi-slot releases, and registering the free count and pool flags.

module cnt_bits #(
   parameter int   W   = 16,
   parameter int   CW  = 5,
   parameter logic ACT = 1'b1
) (
   input  logic [W-1:0]  i_vec,
   output logic [CW-1:0] o_cnt
);

   always_comb begin
      o_cnt = '0;
      for (int i = 0; i < W; i++) begin
         if (i_vec[i] == ACT) o_cnt = o_cnt + CW'(1);
      end
   end

endmodule

module slot_alloc #(
   parameter int DEPTH  = 16,
   parameter int THRESH = 2,
   parameter int IDW    = $clog2(DEPTH),
   parameter int CW     = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_,
   input  logic             alloc_req,
   output logic             alloc_rdy,
   output logic [IDW-1:0]   alloc_id,
   input  logic             free_vld,
   input  logic [DEPTH-1:0] free_vec,
   output logic             free_err,
   output logic [DEPTH-1:0] busy_o,
   output logic [CW-1:0]    free_cnt,
   output logic             full_o,
   output logic             empty_o,
   output logic             low_o
);

   localparam logic [31:0] THRESH_U = 32'(THRESH);
   localparam logic        LOW_RST  = (DEPTH < THRESH) ? 1'b1 : 1'b0;

   logic [DEPTH-1:0] r_busy;
   logic [CW-1:0]    r_free_cnt;
   logic             r_full;
   logic             r_empty;
   logic             r_low;
   logic             r_free_err;

   logic [IDW-1:0]   w_alloc_id;
   logic             w_fire;
   logic [DEPTH-1:0] w_rel;
   logic [DEPTH-1:0] w_grant_oh;
   logic [DEPTH-1:0] w_busy_next;
   logic [DEPTH-1:0] w_free_next;
   logic [CW-1:0]    w_cnt_next;
   logic             w_err_next;
   logic             w_low_next;

   // Scan from the top down so the lowest free index is the last one written.
   always_comb begin
      w_alloc_id = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_busy[i]) w_alloc_id = IDW'(i);
      end
   end

   assign alloc_rdy = ~r_full;
   assign alloc_id  = w_alloc_id;
   assign w_fire    = alloc_req & alloc_rdy;
   assign w_rel     = free_vld ? free_vec : '0;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_grant
         assign w_grant_oh[gi] = w_fire && (w_alloc_id == IDW'(gi));
      end
   endgenerate

   // Grant is chosen from the pre-release bitmap, so a slot freed this cycle
   // only becomes grantable next cycle.
   assign w_busy_next = (r_busy & ~w_rel) | w_grant_oh;
   assign w_free_next = ~w_busy_next;
   assign w_err_next  = |(w_rel & ~r_busy);

   cnt_bits #(
      .W   (DEPTH),
      .CW  (CW),
      .ACT (1'b1)
   ) u_cnt_bits (
      .i_vec (w_free_next),
      .o_cnt (w_cnt_next)
   );

   assign w_low_next = (32'(w_cnt_next) < THRESH_U);

   always_ff @(posedge clk) begin
      if (!reset_) begin
         r_busy     <= '0;
         r_free_cnt <= CW'(DEPTH);
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_low      <= LOW_RST;
         r_free_err <= 1'b0;
      end else begin
         r_busy     <= w_busy_next;
         r_free_cnt <= w_cnt_next;
         r_full     <= (w_cnt_next == '0);
         r_empty    <= (w_cnt_next == CW'(DEPTH));
         r_low      <= w_low_next;
         r_free_err <= w_err_next;
      end
   end

   assign busy_o   = r_busy;
   assign free_cnt = r_free_cnt;
   assign full_o   = r_full;
   assign empty_o  = r_empty;
   assign low_o    = r_low;
   assign free_err = r_free_err;

endmodule

// File: tb/tb_slot_alloc.sv
// Randomized scoreboard bench for slot_alloc: a driver updates a slot-array
// reference model and queues expectations; two monitors pop and compare.

module tb_slot_alloc;

   localparam int DEPTH  = 16;
   localparam int THRESH = 2;
   localparam int IDW    = $clog2(DEPTH);
   localparam int CW     = $clog2(DEPTH) + 1;

   logic             clk;
   logic             reset_;
   logic             alloc_req;
   logic             alloc_rdy;
   logic [IDW-1:0]   alloc_id;
   logic             free_vld;
   logic [DEPTH-1:0] free_vec;
   logic             free_err;
   logic [DEPTH-1:0] busy_o;
   logic [CW-1:0]    free_cnt;
   logic             full_o;
   logic             empty_o;
   logic             low_o;

   slot_alloc #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
      .clk       (clk),
      .reset_    (reset_),
      .alloc_req (alloc_req),
      .alloc_rdy (alloc_rdy),
      .alloc_id  (alloc_id),
      .free_vld  (free_vld),
      .free_vec  (free_vec),
      .free_err  (free_err),
      .busy_o    (busy_o),
      .free_cnt  (free_cnt),
      .full_o    (full_o),
      .empty_o   (empty_o),
      .low_o     (low_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DEPTH-1:0] busy;
      int               cnt;
      bit               full;
      bit               empty;
      bit               low;
      bit               err;
      int               id;
   } exp_t;

   exp_t exp_q[$];
   int   grant_q[$];
   bit   m_busy[DEPTH];
   int   checks   = 0;
   int   failures = 0;
   int   txn      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (txn %0d)", name, act, exp, txn);
      end
   endtask

   function automatic int lowest_free();
      for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return i;
      return -1;
   endfunction

   function automatic int count_free();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) n++;
      return n;
   endfunction

   function automatic logic [DEPTH-1:0] pack_busy();
      logic [DEPTH-1:0] v = '0;
      for (int i = 0; i < DEPTH; i++) v[i] = m_busy[i];
      return v;
   endfunction

   // One clock of stimulus; the model computes what the DUT must show after the edge.
   task automatic step(input bit rst_n, input bit req, input bit fv, input logic [DEPTH-1:0] fvec);
      exp_t e;
      int   g;
      @(negedge clk);
      reset_    = rst_n;
      alloc_req = req;
      free_vld  = fv;
      free_vec  = fvec;
      e.err = 0;
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
      end else begin
         g = lowest_free();
         if (fv) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (fvec[i]) begin
                  if (!m_busy[i]) e.err = 1;
                  m_busy[i] = 0;
               end
            end
         end
         if (req && g >= 0) begin
            m_busy[g] = 1;
            grant_q.push_back(g);
         end
      end
      e.busy  = pack_busy();
      e.cnt   = count_free();
      e.full  = (e.cnt == 0);
      e.empty = (e.cnt == DEPTH);
      e.low   = (e.cnt < THRESH);
      e.id    = lowest_free();
      exp_q.push_back(e);
   endtask

   // State monitor: registered outputs just after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            chk("busy_o",    32'(busy_o),    32'(e.busy));
            chk("free_cnt",  32'(free_cnt),  32'(e.cnt));
            chk("full_o",    32'(full_o),    32'(e.full));
            chk("empty_o",   32'(empty_o),   32'(e.empty));
            chk("low_o",     32'(low_o),     32'(e.low));
            chk("free_err",  32'(free_err),  32'(e.err));
            chk("alloc_rdy", 32'(alloc_rdy), 32'(!e.full));
            if (!e.full) chk("alloc_id", 32'(alloc_id), 32'(e.id));
            $display("txn %0d busy=%h cnt=%0d full=%0b empty=%0b low=%0b err=%0b",
                     txn, busy_o, free_cnt, full_o, empty_o, low_o, free_err);
         end
      end
   end

   // Grant monitor: alloc_id in the cycle the handshake fires.
   initial begin
      int g;
      forever begin
         @(negedge clk);
         #1;
         if (reset_ && alloc_req && alloc_rdy) begin
            if (grant_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL grant_unexpected actual=%0d required=none", alloc_id);
            end else begin
               g = grant_q.pop_front();
               chk("grant_id", 32'(alloc_id), 32'(g));
            end
         end
      end
   end

   initial begin
      logic [DEPTH-1:0] r;
      reset_    = 1'b0;
      alloc_req = 1'b0;
      free_vld  = 1'b0;
      free_vec  = '0;

      // Reset state
      step(0, 0, 0, '0);
      step(0, 0, 0, '0);
      // Fill all 16 slots, then one ignored request
      repeat (17) step(1, 1, 0, '0);
      // Release 5 and 7 from full, then regrant them in order
      step(1, 0, 1, 16'h00A0);
      step(1, 1, 0, '0);
      step(1, 1, 0, '0);
      // Simultaneous alloc and free with busy=000F
      step(0, 0, 0, '0);
      repeat (4) step(1, 1, 0, '0);
      step(1, 1, 1, 16'h0001);
      step(1, 0, 0, '0);
      // Release touching a non-busy slot
      step(0, 0, 0, '0);
      repeat (2) step(1, 1, 0, '0);
      step(1, 0, 1, 16'h0006);
      step(1, 0, 0, '0);
      // Low threshold crossing, then mid-sequence reset
      step(0, 0, 0, '0);
      repeat (15) step(1, 1, 0, '0);
      step(0, 1, 1, 16'h0003);
      step(1, 0, 0, '0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         r = DEPTH'($urandom);
         if ($urandom_range(0, 3) != 0) r = r & pack_busy();
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) < 3), r);
      end
      step(1, 0, 0, '0);
      step(1, 0, 0, '0);

      repeat (3) @(posedge clk);
      #2;
      chk("exp_q_drained",   32'(exp_q.size()),   32'd0);
      chk("grant_q_drained", 32'(grant_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
